// File: rtl/fifo_uart_tx_reader.sv
// Serialises words popped from a show-ahead FIFO onto a UART tx line (start, data LSB first, stop).
// Optional even-parity bit after the data bits: define FIFO_UART_TX_PARITY_EN to include it.
module fifo_uart_tx_reader #(
    parameter int WIDTH     = 8,
    parameter int CLK_DIV   = 16,
    parameter int STOP_BITS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] fifo_data_in,
    input  logic             fifo_empty,
    output logic             fifo_read_ins,
    output logic             tx,
    output logic             tx_busy
);

    localparam int CNT_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_MAX = (WIDTH > STOP_BITS) ? WIDTH : STOP_BITS;
    localparam int IDX_W   = (IDX_MAX > 1) ? $clog2(IDX_MAX) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               rd_q, rd_d;
    logic               tx_q, tx_d;
    logic               bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
    logic               parity_q, parity_d;
`endif

    assign bit_end = (cnt_q == CNT_LAST);

    // tx is computed one cycle ahead so the line itself comes straight from a flop.
    always_comb begin
        // NOTE: every signal gets a default before the case; a path that leaves one unassigned infers a latch.
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CNT_W'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        rd_d    = 1'b0;
        tx_d    = tx_q;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                tx_d  = 1'b1;
                if (enable && !fifo_empty) begin
                    state_d = START;
                    shift_d = fifo_data_in;
                    rd_d    = 1'b1;
                    tx_d    = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
                    parity_d = ^fifo_data_in;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (idx_q == BIT_LAST) begin
                        idx_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        state_d = PARITY;
                        tx_d    = parity_q;
`else
                        state_d = STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                    end
                end
            end
`ifdef FIFO_UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
`endif
            STOP: begin
                tx_d = 1'b1;
                if (bit_end) begin
                    if (idx_q == STOP_LAST) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Reset drops any latched word; the FIFO already popped it and is not re-read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            rd_q     <= 1'b0;
            tx_q     <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            rd_q     <= rd_d;
            tx_q     <= tx_d;
`ifdef FIFO_UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign fifo_read_ins = rd_q;
    assign tx            = tx_q;
    assign tx_busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx_reader.sv
// Directed bench for fifo_uart_tx_reader with CLK_DIV=4, WIDTH=8, one stop bit.
// Inputs are driven and outputs sampled on the falling edge; a small show-ahead FIFO model feeds the DUT.
module tb_fifo_uart_tx_reader;

    localparam int CLK_DIV = 4;
    localparam int WIDTH   = 8;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CLK_DIV;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [WIDTH-1:0] fifo_data_in;
    logic             fifo_empty;
    logic             fifo_read_ins;
    logic             tx;
    logic             tx_busy;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] mem [16];
    logic [3:0]       rd_ptr = '0;
    logic [3:0]       wr_ptr = '0;
    int               pop_cnt = 0;
    logic             bad_pop = 1'b0;

    fifo_uart_tx_reader #(
        .WIDTH    (WIDTH),
        .CLK_DIV  (CLK_DIV),
        .STOP_BITS(1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .fifo_data_in (fifo_data_in),
        .fifo_empty   (fifo_empty),
        .fifo_read_ins(fifo_read_ins),
        .tx           (tx),
        .tx_busy      (tx_busy)
    );

    always #5 clk = ~clk;

    assign fifo_empty   = (rd_ptr == wr_ptr);
    assign fifo_data_in = mem[rd_ptr];

    always @(posedge clk) begin
        if (fifo_read_ins) begin
            if (fifo_empty) bad_pop <= 1'b1;
            rd_ptr  <= rd_ptr + 4'd1;
            pop_cnt <= pop_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 4'd1;
    endtask

    // Waits (bounded) for tx_busy; a frame started at the next edge gives lat=1.
    task automatic wait_busy(input string tag);
        int lat;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (tx_busy) break;
        end
        check({tag, "_start_latency"}, lat, 1);
    endtask

    // Called at the first falling edge of a frame; ends at the idle sample after it.
    task automatic check_frame(input string tag, input logic [7:0] data, input logic par,
                               input int drop_en_at);
        logic [10:0] exp;
        exp = '1;
        exp[0] = 1'b0;
        exp[8:1] = data;
`ifdef FIFO_UART_TX_PARITY_EN
        exp[9] = par;
`else
        exp[9] = 1'b1 | par;
`endif
        for (int k = 0; k < FRAME; k++) begin
            if (k == drop_en_at) enable = 1'b0;
            check($sformatf("%s_tx_c%0d", tag, k), tx, exp[k / CLK_DIV]);
            check($sformatf("%s_busy_c%0d", tag, k), tx_busy, 1'b1);
            check($sformatf("%s_pop_c%0d", tag, k), fifo_read_ins, (k == 0) ? 1'b1 : 1'b0);
            @(negedge clk);
        end
        check({tag, "_end_busy"}, tx_busy, 1'b0);
        check({tag, "_end_tx"}, tx, 1'b1);
    endtask

    initial begin
        int p0;
        logic saw_busy, saw_low, saw_pop;

        rst = 1'b1;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_pop", fifo_read_ins, 1'b0);
        rst = 1'b0;

        // Empty FIFO with enable held: line stays idle and nothing pops.
        enable = 1'b1;
        saw_busy = 1'b0; saw_low = 1'b0; saw_pop = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_busy) saw_busy = 1'b1;
            if (!tx) saw_low = 1'b1;
            if (fifo_read_ins) saw_pop = 1'b1;
        end
        check("empty_busy", saw_busy, 1'b0);
        check("empty_tx_low", saw_low, 1'b0);
        check("empty_pop", saw_pop, 1'b0);
        check("empty_pop_cnt", pop_cnt, 0);

        // Single frame 0xA5: wire order 0,1,0,1,0,0,1,0,1,(parity 0),1.
        push(8'hA5);
        wait_busy("a5");
        check_frame("a5", 8'hA5, 1'b0, -1);
        check("a5_pops", pop_cnt, 1);

        // Back-to-back 0x01, 0x80 with one idle cycle between them.
        p0 = pop_cnt;
        push(8'h01);
        push(8'h80);
        wait_busy("b2b0");
        check_frame("b2b0", 8'h01, 1'b1, -1);
        @(negedge clk);
        check("b2b_gap_busy", tx_busy, 1'b1);
        check_frame("b2b1", 8'h80, 1'b1, -1);
        check("b2b_pops", pop_cnt - p0, 2);
        check("b2b_empty", fifo_empty, 1'b1);

        // Enable dropped during START with three words queued.
        p0 = pop_cnt;
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_busy("drop");
        check_frame("drop", 8'h11, 1'b0, 1);
        saw_busy = 1'b0; saw_pop = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (tx_busy) saw_busy = 1'b1;
            if (fifo_read_ins) saw_pop = 1'b1;
        end
        check("drop_idle_busy", saw_busy, 1'b0);
        check("drop_idle_pop", saw_pop, 1'b0);
        check("drop_pops", pop_cnt - p0, 1);
        check("drop_left", 32'(wr_ptr - rd_ptr), 2);

        // Reset during data bit 3 of 0x3C; 0x55 stays queued and is the next frame.
        wr_ptr = rd_ptr;
        push(8'h3C);
        push(8'h55);
        enable = 1'b1;
        wait_busy("rst");
        repeat (4 + 3 * CLK_DIV + 1) @(negedge clk);
        check("rst_mid_busy_before", tx_busy, 1'b1);
        p0 = pop_cnt;
        rst = 1'b1;
        #1;
        check("rst_mid_tx", tx, 1'b1);
        check("rst_mid_busy", tx_busy, 1'b0);
        check("rst_mid_pop", fifo_read_ins, 1'b0);
        repeat (3) @(negedge clk);
        check("rst_hold_pops", pop_cnt - p0, 0);
        check("rst_hold_tx", tx, 1'b1);
        rst = 1'b0;
        wait_busy("after_rst");
        check_frame("after_rst", 8'h55, 1'b0, -1);
        check("after_rst_pops", pop_cnt - p0, 1);

`ifdef FIFO_UART_TX_PARITY_EN
        // Odd count of ones: parity bit 1.
        push(8'h07);
        wait_busy("p07");
        check_frame("p07", 8'h07, 1'b1, -1);
`endif

        enable = 1'b0;
        repeat (2) @(negedge clk);
        check("no_pop_while_empty", bad_pop, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
